// File: rtl/id_stage_pkg.sv
// Shared bus layouts, opcode/funct constants and ALU one-hot positions for the
// decode stage.
package id_stage_pkg;

    localparam int IF_TO_ID_BUS_WD  = 64;
    localparam int ID_TO_PC_BUS_WD  = 98;
    localparam int ID_TO_EXE_BUS_WD = 136;
    localparam int WB_TO_RF_BUS_WD  = 38;

    localparam int ALU_OP_W = 12;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_JAL = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    typedef struct packed {
        logic [31:0] pc_plus_4;
        logic [31:0] inst;
    } if_to_id_t;

    typedef struct packed {
        logic [31:0] br_target;
        logic [31:0] jal_target;
        logic [31:0] jr_target;
        npc_sel_e    sel_next_pc;
    } id_to_pc_t;

    // Bit 115 is an unused pad between the control flags and dest.
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic        src1_is_sa;
        logic        src1_is_pc;
        logic        src2_is_imm;
        logic        src2_is_zimm;
        logic        src2_is_8;
        logic        res_from_mem;
        logic        gr_we;
        logic        mem_we;
        logic        rsvd;
        logic [4:0]  dest;
        logic [15:0] imm;
        logic [31:0] rs_value;
        logic [31:0] rt_value;
        logic [29:0] pc;
    } id_to_exe_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_to_rf_t;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two combinational read ports, one posedge write port.
// r0 reads as zero and ignores writes; no write-to-read bypass.
module regfile (
    input  logic        clk,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] r_rf [32];

    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            r_rf[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : r_rf[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : r_rf[raddr2];

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: latches fetch payload, decodes, reads operands, resolves
// branches/jumps and stalls on read-after-write hazards (no forwarding).
module id_stage
    import id_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        IF_to_ID_valid,
    input  logic [IF_TO_ID_BUS_WD-1:0]  IF_to_ID_bus,
    output logic                        ID_allow_in,
    output logic [ID_TO_PC_BUS_WD-1:0]  ID_to_PC_bus,
    input  logic                        EXE_allow_in,
    output logic                        ID_to_EXE_valid,
    output logic [ID_TO_EXE_BUS_WD-1:0] ID_to_EXE_bus,
    input  logic [4:0]                  EXE_dest,
    input  logic [4:0]                  MEM_dest,
    input  logic [4:0]                  WB_dest,
    input  logic [WB_TO_RF_BUS_WD-1:0]  WB_to_RF_bus
);

    logic      r_valid;
    if_to_id_t r_payload;

    logic w_ready_go;
    logic w_hazard;

    assign ID_allow_in     = ~r_valid | (w_ready_go & EXE_allow_in);
    assign ID_to_EXE_valid = r_valid & w_ready_go;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= 1'b0;
        end else if (ID_allow_in) begin
            r_valid <= IF_to_ID_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (IF_to_ID_valid && ID_allow_in) begin
            r_payload <= IF_to_ID_bus;
        end
    end

    // Field split
    logic [31:0] w_inst;
    logic [31:0] w_pc_plus_4;
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;

    assign w_inst      = r_payload.inst;
    assign w_pc_plus_4 = r_payload.pc_plus_4;
    assign w_op        = w_inst[31:26];
    assign w_rs        = w_inst[25:21];
    assign w_rt        = w_inst[20:16];
    assign w_rd        = w_inst[15:11];
    assign w_funct     = w_inst[5:0];
    assign w_imm       = w_inst[15:0];

    logic w_special;
    logic w_addu, w_subu, w_slt, w_sltu, w_and, w_or, w_xor, w_nor;
    logic w_sll, w_srl, w_sra, w_jr;
    logic w_addiu, w_lui, w_lw, w_sw, w_beq, w_bne, w_jal;
    logic w_shift, w_alu_r;

    assign w_special = (w_op == OP_SPECIAL);
    assign w_addu    = w_special & (w_funct == FN_ADDU);
    assign w_subu    = w_special & (w_funct == FN_SUBU);
    assign w_slt     = w_special & (w_funct == FN_SLT);
    assign w_sltu    = w_special & (w_funct == FN_SLTU);
    assign w_and     = w_special & (w_funct == FN_AND);
    assign w_or      = w_special & (w_funct == FN_OR);
    assign w_xor     = w_special & (w_funct == FN_XOR);
    assign w_nor     = w_special & (w_funct == FN_NOR);
    assign w_sll     = w_special & (w_funct == FN_SLL);
    assign w_srl     = w_special & (w_funct == FN_SRL);
    assign w_sra     = w_special & (w_funct == FN_SRA);
    assign w_jr      = w_special & (w_funct == FN_JR);
    assign w_addiu   = (w_op == OP_ADDIU);
    assign w_lui     = (w_op == OP_LUI);
    assign w_lw      = (w_op == OP_LW);
    assign w_sw      = (w_op == OP_SW);
    assign w_beq     = (w_op == OP_BEQ);
    assign w_bne     = (w_op == OP_BNE);
    assign w_jal     = (w_op == OP_JAL);

    assign w_shift = w_sll | w_srl | w_sra;
    assign w_alu_r = w_addu | w_subu | w_slt | w_sltu | w_and | w_or
                   | w_xor | w_nor | w_shift;

    logic [ALU_OP_W-1:0] w_alu_op;

    always_comb begin
        w_alu_op           = '0;
        w_alu_op[ALU_ADD]  = w_addu | w_addiu | w_lw | w_sw | w_jal;
        w_alu_op[ALU_SUB]  = w_subu;
        w_alu_op[ALU_SLT]  = w_slt;
        w_alu_op[ALU_SLTU] = w_sltu;
        w_alu_op[ALU_AND]  = w_and;
        w_alu_op[ALU_NOR]  = w_nor;
        w_alu_op[ALU_OR]   = w_or;
        w_alu_op[ALU_XOR]  = w_xor;
        w_alu_op[ALU_SLL]  = w_sll;
        w_alu_op[ALU_SRL]  = w_srl;
        w_alu_op[ALU_SRA]  = w_sra;
        w_alu_op[ALU_LUI]  = w_lui;
    end

    logic [4:0] w_dest;
    logic       w_gr_we;

    assign w_gr_we = w_alu_r | w_addiu | w_lui | w_lw | w_jal;
    assign w_dest  = w_alu_r                     ? w_rd  :
                     (w_addiu | w_lui | w_lw)    ? w_rt  :
                     w_jal                       ? 5'd31 : 5'd0;

    // Operand read
    wb_to_rf_t   w_wb;
    logic [31:0] w_rs_value;
    logic [31:0] w_rt_value;

    assign w_wb = WB_to_RF_bus;

    regfile u_regfile (
        .clk    (clk),
        .raddr1 (w_rs),
        .rdata1 (w_rs_value),
        .raddr2 (w_rt),
        .rdata2 (w_rt_value),
        .we     (w_wb.we),
        .waddr  (w_wb.waddr),
        .wdata  (w_wb.wdata)
    );

    // Hazard: WB compare also covers the write landing at the coming edge.
    logic w_rs_read, w_rt_read, w_rs_hit, w_rt_hit;

    assign w_rs_read = (w_alu_r & ~w_shift) | w_addiu | w_lw | w_sw
                     | w_beq | w_bne | w_jr;
    assign w_rt_read = w_alu_r | w_sw | w_beq | w_bne;

    assign w_rs_hit = w_rs_read && (w_rs != 5'd0) &&
                      ((w_rs == EXE_dest) || (w_rs == MEM_dest) || (w_rs == WB_dest));
    assign w_rt_hit = w_rt_read && (w_rt != 5'd0) &&
                      ((w_rt == EXE_dest) || (w_rt == MEM_dest) || (w_rt == WB_dest));

    assign w_hazard   = w_rs_hit | w_rt_hit;
    assign w_ready_go = ~w_hazard;

    // Redirect
    id_to_pc_t w_pc_bus;
    logic      w_rs_eq_rt;

    assign w_rs_eq_rt = (w_rs_value == w_rt_value);

    always_comb begin
        w_pc_bus.br_target   = w_pc_plus_4 + branch_offset(w_imm);
        w_pc_bus.jal_target  = {w_pc_plus_4[31:28], w_inst[25:0], 2'b00};
        w_pc_bus.jr_target   = w_rs_value;
        w_pc_bus.sel_next_pc = NPC_SEQ;
        if (r_valid && w_ready_go) begin
            if ((w_beq && w_rs_eq_rt) || (w_bne && !w_rs_eq_rt)) begin
                w_pc_bus.sel_next_pc = NPC_BR;
            end else if (w_jal) begin
                w_pc_bus.sel_next_pc = NPC_JAL;
            end else if (w_jr) begin
                w_pc_bus.sel_next_pc = NPC_JR;
            end
        end
    end

    assign ID_to_PC_bus = w_pc_bus;

    // Execute payload
    id_to_exe_t  w_exe_bus;
    logic [31:0] w_pc;

    assign w_pc = w_pc_plus_4 - 32'd4;

    always_comb begin
        w_exe_bus.alu_op       = w_alu_op;
        w_exe_bus.src1_is_sa   = w_shift;
        w_exe_bus.src1_is_pc   = w_jal;
        w_exe_bus.src2_is_imm  = w_addiu | w_lui | w_lw | w_sw;
        w_exe_bus.src2_is_zimm = 1'b0;
        w_exe_bus.src2_is_8    = w_jal;
        w_exe_bus.res_from_mem = w_lw;
        w_exe_bus.gr_we        = w_gr_we;
        w_exe_bus.mem_we       = w_sw;
        w_exe_bus.rsvd         = 1'b0;
        w_exe_bus.dest         = w_dest;
        w_exe_bus.imm          = w_imm;
        w_exe_bus.rs_value     = w_rs_value;
        w_exe_bus.rt_value     = w_rt_value;
        w_exe_bus.pc           = w_pc[31:2];
    end

    assign ID_to_EXE_bus = w_exe_bus;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, RAW stall, branches, jal/jr, decode,
// execute backpressure and reset during a stall.
module tb_id_stage;
    import id_stage_pkg::*;

    logic                        clk = 1'b0;
    logic                        resetn;
    logic                        IF_to_ID_valid;
    logic [IF_TO_ID_BUS_WD-1:0]  IF_to_ID_bus;
    logic                        ID_allow_in;
    logic [ID_TO_PC_BUS_WD-1:0]  ID_to_PC_bus;
    logic                        EXE_allow_in;
    logic                        ID_to_EXE_valid;
    logic [ID_TO_EXE_BUS_WD-1:0] ID_to_EXE_bus;
    logic [4:0]                  EXE_dest, MEM_dest, WB_dest;
    logic [WB_TO_RF_BUS_WD-1:0]  WB_to_RF_bus;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .IF_to_ID_valid  (IF_to_ID_valid),
        .IF_to_ID_bus    (IF_to_ID_bus),
        .ID_allow_in     (ID_allow_in),
        .ID_to_PC_bus    (ID_to_PC_bus),
        .EXE_allow_in    (EXE_allow_in),
        .ID_to_EXE_valid (ID_to_EXE_valid),
        .ID_to_EXE_bus   (ID_to_EXE_bus),
        .EXE_dest        (EXE_dest),
        .MEM_dest        (MEM_dest),
        .WB_dest         (WB_dest),
        .WB_to_RF_bus    (WB_to_RF_bus)
    );

    // Field views taken straight from the documented bit positions
    logic [11:0] e_alu;
    logic [7:0]  e_flags;
    logic [4:0]  e_dest;
    logic [15:0] e_imm;
    logic [31:0] e_rs, e_rt;
    logic [29:0] e_pc;
    logic [31:0] p_br, p_jal, p_jr;
    logic [1:0]  p_sel;

    assign e_alu   = ID_to_EXE_bus[135:124];
    assign e_flags = ID_to_EXE_bus[123:116];
    assign e_dest  = ID_to_EXE_bus[114:110];
    assign e_imm   = ID_to_EXE_bus[109:94];
    assign e_rs    = ID_to_EXE_bus[93:62];
    assign e_rt    = ID_to_EXE_bus[61:30];
    assign e_pc    = ID_to_EXE_bus[29:0];
    assign p_br    = ID_to_PC_bus[97:66];
    assign p_jal   = ID_to_PC_bus[65:34];
    assign p_jr    = ID_to_PC_bus[33:2];
    assign p_sel   = ID_to_PC_bus[1:0];

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        IF_to_ID_valid = 1'b0;
        IF_to_ID_bus   = '0;
        EXE_allow_in   = 1'b1;
        EXE_dest       = 5'd0;
        MEM_dest       = 5'd0;
        WB_dest        = 5'd0;
        WB_to_RF_bus   = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        // A write during reset still lands: preload $3 for later tests.
        WB_to_RF_bus = {1'b1, 5'd3, 32'h0000_1234};
        repeat (3) tick();
        WB_to_RF_bus = '0;
        n_tests++;
        if ({ID_allow_in, ID_to_EXE_valid, p_sel} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_state: got allow/valid/sel=%b required 1000",
                     {ID_allow_in, ID_to_EXE_valid, p_sel});
        end
        resetn = 1'b1;
        settle();
    endtask

    task automatic test_raw_stall();
        IF_to_ID_valid = 1'b1;
        IF_to_ID_bus   = {32'hbfc0_0004, itype(OP_ADDIU, 5'd0, 5'd1, 16'd5)};
        tick();
        IF_to_ID_bus   = {32'hbfc0_0008, rtype(5'd1, 5'd1, 5'd2, 5'd0, FN_ADDU)};
        settle();
        n_tests++;
        if ({ID_to_EXE_valid, e_alu, e_flags, e_dest, e_imm, e_pc} !==
            {1'b1, 12'h001, 8'b0010_0010, 5'd1, 16'd5, 30'h2ff0_0000}) begin
            n_fail++;
            $display("FAIL addiu_issue: got v=%b alu=%h fl=%b dest=%0d imm=%h pc=%h required 1 001 00100010 1 0005 2ff00000",
                     ID_to_EXE_valid, e_alu, e_flags, e_dest, e_imm, e_pc);
        end
        tick();
        IF_to_ID_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            EXE_dest = (c == 0) ? 5'd1 : 5'd0;
            MEM_dest = (c == 1) ? 5'd1 : 5'd0;
            WB_dest  = (c == 2) ? 5'd1 : 5'd0;
            WB_to_RF_bus = (c == 2) ? {1'b1, 5'd1, 32'd5} : '0;
            settle();
            n_tests++;
            if ({ID_to_EXE_valid, ID_allow_in} !== 2'b00) begin
                n_fail++;
                $display("FAIL raw_stall_%0d: got valid/allow=%b required 00",
                         c, {ID_to_EXE_valid, ID_allow_in});
            end
            tick();
        end
        idle();
        settle();
        n_tests++;
        if ({ID_to_EXE_valid, e_rs, e_rt, e_dest, e_alu} !== {1'b1, 32'd5, 32'd5, 5'd2, 12'h001}) begin
            n_fail++;
            $display("FAIL raw_release: got v=%b rs=%h rt=%h dest=%0d alu=%h required 1 5 5 2 001",
                     ID_to_EXE_valid, e_rs, e_rt, e_dest, e_alu);
        end
        tick();
        n_tests++;
        if (ID_to_EXE_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_drain: got valid=%b required 0", ID_to_EXE_valid);
        end
    endtask

    task automatic test_branch();
        IF_to_ID_valid = 1'b1;
        IF_to_ID_bus   = {32'hbfc0_0004, itype(OP_BEQ, 5'd0, 5'd0, 16'h0004)};
        tick();
        IF_to_ID_bus   = {32'hbfc0_0008, 32'h0000_0000};
        settle();
        n_tests++;
        if ({p_sel, p_br, ID_allow_in, e_dest, e_flags[1]} !== {2'b01, 32'hbfc0_0014, 1'b1, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL beq_taken: got sel=%b br=%h allow=%b dest=%0d we=%b required 01 bfc00014 1 0 0",
                     p_sel, p_br, ID_allow_in, e_dest, e_flags[1]);
        end
        tick();
        IF_to_ID_bus   = {32'hbfc0_0010, itype(OP_BNE, 5'd3, 5'd3, 16'hffff)};
        settle();
        n_tests++;
        if ({ID_to_EXE_valid, e_pc, p_sel} !== {1'b1, 30'h2ff0_0001, 2'b00}) begin
            n_fail++;
            $display("FAIL delay_slot: got v=%b pc=%h sel=%b required 1 2ff00001 00",
                     ID_to_EXE_valid, e_pc, p_sel);
        end
        tick();
        IF_to_ID_valid = 1'b0;
        settle();
        n_tests++;
        if ({p_sel, p_br, e_rs} !== {2'b00, 32'hbfc0_000c, 32'h0000_1234}) begin
            n_fail++;
            $display("FAIL bne_not_taken: got sel=%b br=%h rs=%h required 00 bfc0000c 00001234",
                     p_sel, p_br, e_rs);
        end
        tick();
    endtask

    task automatic test_stalled_branch();
        IF_to_ID_valid = 1'b1;
        IF_to_ID_bus   = {32'hbfc0_0020, itype(OP_BEQ, 5'd3, 5'd3, 16'h0002)};
        EXE_dest       = 5'd3;
        tick();
        IF_to_ID_valid = 1'b0;
        settle();
        n_tests++;
        if ({ID_to_EXE_valid, p_sel} !== 3'b000) begin
            n_fail++;
            $display("FAIL branch_stall_hold: got valid/sel=%b required 000", {ID_to_EXE_valid, p_sel});
        end
        EXE_dest = 5'd0;
        settle();
        n_tests++;
        if ({ID_to_EXE_valid, p_sel, p_br} !== {1'b1, 2'b01, 32'hbfc0_0028}) begin
            n_fail++;
            $display("FAIL branch_stall_release: got v=%b sel=%b br=%h required 1 01 bfc00028",
                     ID_to_EXE_valid, p_sel, p_br);
        end
        tick();
    endtask

    task automatic test_jal_jr();
        IF_to_ID_valid = 1'b1;
        IF_to_ID_bus   = {32'hbfc0_0008, OP_JAL, 26'h010_0000};
        tick();
        IF_to_ID_valid = 1'b0;
        settle();
        n_tests++;
        if ({p_sel, p_jal, e_dest, e_flags, e_alu} !== {2'b10, 32'hb040_0000, 5'd31, 8'b0100_1010, 12'h001}) begin
            n_fail++;
            $display("FAIL jal: got sel=%b tgt=%h dest=%0d fl=%b alu=%h required 10 b0400000 31 01001010 001",
                     p_sel, p_jal, e_dest, e_flags, e_alu);
        end
        tick();
        WB_to_RF_bus   = {1'b1, 5'd31, 32'hbfc0_0010};
        IF_to_ID_valid = 1'b1;
        IF_to_ID_bus   = {32'hbfc0_0010, rtype(5'd31, 5'd0, 5'd0, 5'd0, FN_JR)};
        tick();
        IF_to_ID_valid = 1'b0;
        WB_to_RF_bus   = '0;
        settle();
        n_tests++;
        if ({p_sel, p_jr, e_dest, e_flags[1]} !== {2'b11, 32'hbfc0_0010, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL jr: got sel=%b tgt=%h dest=%0d we=%b required 11 bfc00010 0 0",
                     p_sel, p_jr, e_dest, e_flags[1]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [13];
        logic [11:0] alus  [13];
        logic [4:0]  dests [13];
        logic [7:0]  flags [13];
        insts[0]  = rtype(5'd0, 5'd0, 5'd8, 5'd0, FN_SUBU); alus[0]  = 12'h002; dests[0]  = 5'd8;  flags[0]  = 8'b0000_0010;
        insts[1]  = rtype(5'd0, 5'd0, 5'd8, 5'd0, FN_SLT);  alus[1]  = 12'h004; dests[1]  = 5'd8;  flags[1]  = 8'b0000_0010;
        insts[2]  = rtype(5'd0, 5'd0, 5'd8, 5'd0, FN_SLTU); alus[2]  = 12'h008; dests[2]  = 5'd8;  flags[2]  = 8'b0000_0010;
        insts[3]  = rtype(5'd0, 5'd0, 5'd8, 5'd0, FN_AND);  alus[3]  = 12'h010; dests[3]  = 5'd8;  flags[3]  = 8'b0000_0010;
        insts[4]  = rtype(5'd0, 5'd0, 5'd8, 5'd0, FN_NOR);  alus[4]  = 12'h020; dests[4]  = 5'd8;  flags[4]  = 8'b0000_0010;
        insts[5]  = rtype(5'd0, 5'd0, 5'd8, 5'd0, FN_OR);   alus[5]  = 12'h040; dests[5]  = 5'd8;  flags[5]  = 8'b0000_0010;
        insts[6]  = rtype(5'd0, 5'd0, 5'd8, 5'd0, FN_XOR);  alus[6]  = 12'h080; dests[6]  = 5'd8;  flags[6]  = 8'b0000_0010;
        insts[7]  = rtype(5'd0, 5'd0, 5'd8, 5'd2, FN_SLL);  alus[7]  = 12'h100; dests[7]  = 5'd8;  flags[7]  = 8'b1000_0010;
        insts[8]  = rtype(5'd0, 5'd0, 5'd8, 5'd2, FN_SRL);  alus[8]  = 12'h200; dests[8]  = 5'd8;  flags[8]  = 8'b1000_0010;
        insts[9]  = rtype(5'd0, 5'd0, 5'd8, 5'd2, FN_SRA);  alus[9]  = 12'h400; dests[9]  = 5'd8;  flags[9]  = 8'b1000_0010;
        insts[10] = itype(OP_LUI, 5'd0, 5'd9, 16'h1234);    alus[10] = 12'h800; dests[10] = 5'd9;  flags[10] = 8'b0010_0010;
        insts[11] = itype(OP_SW, 5'd0, 5'd0, 16'h0004);     alus[11] = 12'h001; dests[11] = 5'd0;  flags[11] = 8'b0010_0001;
        insts[12] = itype(6'h3f, 5'd1, 5'd2, 16'h0000);     alus[12] = 12'h000; dests[12] = 5'd0;  flags[12] = 8'b0000_0000;
        for (int i = 0; i < 13; i++) begin
            IF_to_ID_valid = 1'b1;
            IF_to_ID_bus   = {32'hbfc0_0100, insts[i]};
            tick();
            settle();
            n_tests++;
            if ({ID_to_EXE_valid, e_alu, e_dest, e_flags, p_sel} !== {1'b1, alus[i], dests[i], flags[i], 2'b00}) begin
                n_fail++;
                $display("FAIL decode_%0d: got v=%b alu=%h dest=%0d fl=%b sel=%b required 1 %h %0d %b 00",
                         i, ID_to_EXE_valid, e_alu, e_dest, e_flags, p_sel, alus[i], dests[i], flags[i]);
            end
        end
        IF_to_ID_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        IF_to_ID_valid = 1'b1;
        IF_to_ID_bus   = {32'hbfc0_0030, itype(OP_LW, 5'd0, 5'd4, 16'h0008)};
        tick();
        IF_to_ID_bus   = {32'hbfc0_0034, itype(OP_ADDIU, 5'd0, 5'd5, 16'h0001)};
        EXE_allow_in   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            WB_to_RF_bus = (c == 1) ? {1'b1, 5'd0, 32'hdead_beef} : '0;
            settle();
            n_tests++;
            if ({ID_allow_in, ID_to_EXE_valid, e_dest, e_imm, e_flags[2], e_rs, e_pc} !==
                {1'b0, 1'b1, 5'd4, 16'h0008, 1'b1, 32'd0, 30'h2ff0_000b}) begin
                n_fail++;
                $display("FAIL backpressure_%0d: got allow=%b v=%b dest=%0d imm=%h rfm=%b rs=%h pc=%h required 0 1 4 0008 1 0 2ff0000b",
                         c, ID_allow_in, ID_to_EXE_valid, e_dest, e_imm, e_flags[2], e_rs, e_pc);
            end
            tick();
        end
        WB_to_RF_bus = '0;
        EXE_allow_in = 1'b1;
        settle();
        n_tests++;
        if ({ID_allow_in, e_rs} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL r0_after_write: got allow=%b rs=%h required 1 00000000", ID_allow_in, e_rs);
        end
        tick();
        IF_to_ID_valid = 1'b0;
        settle();
        n_tests++;
        if ({ID_to_EXE_valid, e_dest} !== {1'b1, 5'd5}) begin
            n_fail++;
            $display("FAIL backpressure_release: got v=%b dest=%0d required 1 5", ID_to_EXE_valid, e_dest);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        IF_to_ID_valid = 1'b1;
        IF_to_ID_bus   = {32'hbfc0_0040, rtype(5'd3, 5'd3, 5'd5, 5'd0, FN_ADDU)};
        EXE_dest       = 5'd3;
        tick();
        IF_to_ID_valid = 1'b0;
        settle();
        n_tests++;
        if (ID_to_EXE_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stall_pre: got valid=%b required 0", ID_to_EXE_valid);
        end
        resetn       = 1'b0;
        WB_to_RF_bus = {1'b1, 5'd6, 32'd77};
        tick();
        resetn       = 1'b1;
        WB_to_RF_bus = '0;
        EXE_dest     = 5'd0;
        settle();
        n_tests++;
        if ({ID_to_EXE_valid, ID_allow_in} !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_stall_reset: got valid/allow=%b required 01", {ID_to_EXE_valid, ID_allow_in});
        end
        IF_to_ID_valid = 1'b1;
        IF_to_ID_bus   = {32'hbfc0_0044, rtype(5'd6, 5'd0, 5'd7, 5'd0, FN_ADDU)};
        tick();
        IF_to_ID_valid = 1'b0;
        settle();
        n_tests++;
        if ({ID_to_EXE_valid, e_rs} !== {1'b1, 32'd77}) begin
            n_fail++;
            $display("FAIL reset_write_commit: got v=%b rs=%h required 1 0000004d", ID_to_EXE_valid, e_rs);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_branch();
        test_stalled_branch();
        test_jal_jr();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
